// File: rtl/mux_pkg.sv
// Shared constants and round-robin helper for the N:1 registered multiplexer.
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    localparam int MUX_N_DEFAULT  = 4;
    localparam int MUX_W_DEFAULT  = 8;
    localparam int MUX_CW_DEFAULT = 16;

    // Successor of idx in a cyclic 0..n-1 ring.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester found searching cyclically after last_grant.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N = MUX_N_DEFAULT,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] last_grant,
    output logic          grant_valid,
    output logic [SW-1:0] grant_idx
);

    // Cyclic priority search starting one past the previous winner.
    always_comb begin : search
        int unsigned cand;
        logic        hit;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 32'(last_grant);
        hit         = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand        = rr_next(cand, N);
            hit         = req[cand] & ~grant_valid;
            grant_idx   = hit ? SW'(cand) : grant_idx;
            grant_valid = grant_valid | hit;
        end
    end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-channel W-bit registered mux with valid/ready, explicit-select or round-robin.
// Define MUX_GRANT_CNT_EN to add saturating per-channel grant counters on grant_cnt.
module mux_nto1_rr
    import mux_pkg::*;
#(
    parameter int N  = MUX_N_DEFAULT,
    parameter int W  = MUX_W_DEFAULT
`ifdef MUX_GRANT_CNT_EN
    ,
    parameter int CW = MUX_CW_DEFAULT
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N*W-1:0]          data_in,
    input  logic [N-1:0]            in_valid,
    output logic [N-1:0]            in_ready,
    input  logic                    mode,
    input  logic [$clog2(N)-1:0]    sel,
    output logic [W-1:0]            out_data,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef MUX_GRANT_CNT_EN
    ,
    output logic [N*CW-1:0]         grant_cnt
`endif
);

    localparam int SW = $clog2(N);
    localparam int NP = 1 << SW;
    localparam logic [SW-1:0] LAST_RST = SW'(N - 1);

    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] last_grant_q, last_grant_d;

    logic          load_s;
    logic          transfer_s;
    logic          grant_valid_s;
    logic [SW-1:0] grant_idx_s;
    logic          rr_valid_s;
    logic [SW-1:0] rr_idx_s;
    logic [NP-1:0] valid_ext_s;
    logic [W-1:0]  sel_data_s;

    rr_arbiter #(.N(N)) u_rr_arbiter (
        .req         (in_valid),
        .last_grant  (last_grant_q),
        .grant_valid (rr_valid_s),
        .grant_idx   (rr_idx_s)
    );

    // Grant selection, handshake and next-state for the output stage.
    always_comb begin
        // Out-of-range select indices land on zero-padded valid bits and never grant.
        valid_ext_s        = '0;
        valid_ext_s[N-1:0] = in_valid;

        case (mode)
            MODE_SEL: begin
                grant_valid_s = valid_ext_s[sel];
                grant_idx_s   = sel;
            end
            MODE_RR: begin
                grant_valid_s = rr_valid_s;
                grant_idx_s   = rr_idx_s;
            end
            default: begin
                grant_valid_s = 1'b0;
                grant_idx_s   = '0;
            end
        endcase

        load_s     = ~out_valid_q | out_ready;
        transfer_s = load_s & grant_valid_s;

        in_ready = '0;
        if (transfer_s) begin
            in_ready[grant_idx_s] = 1'b1;
        end else begin
            in_ready = '0;
        end

        sel_data_s = '0;
        for (int i = 0; i < N; i++) begin
            sel_data_s = (grant_idx_s == SW'(i)) ? data_in[i*W +: W] : sel_data_s;
        end

        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        if (load_s) begin
            out_valid_d = grant_valid_s;
            if (grant_valid_s) begin
                out_data_d   = sel_data_s;
                last_grant_d = grant_idx_s;
            end else begin
                out_data_d   = out_data_q;
                last_grant_d = last_grant_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register and arbitration history.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            last_grant_q <= LAST_RST;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

`ifdef MUX_GRANT_CNT_EN
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    // Saturating per-channel transfer counters.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (transfer_s && (grant_idx_s == SW'(i)) && (cnt_q[i] != {CW{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Counter storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N; i++) begin
            grant_cnt[i*CW +: CW] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Self-checking bench for mux_nto1_rr: vector table, corner sequences, randomized model check.
module tb_mux_nto1_rr;

    localparam int N  = 4;
    localparam int W  = 8;
`ifdef MUX_GRANT_CNT_EN
    localparam int CW = 2;
`endif

    logic           clk;
    logic           rst;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [1:0]     sel;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
`ifdef MUX_GRANT_CNT_EN
    logic [N*CW-1:0] grant_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mux_nto1_rr #(
        .N (N),
        .W (W)
`ifdef MUX_GRANT_CNT_EN
        ,
        .CW(CW)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reference model state (random phase)
    logic       m_ov;
    logic [7:0] m_data;
    int         m_last;

    initial begin
        rst       = 1'b1;
        data_in   = '0;
        in_valid  = '0;
        mode      = 1'b0;
        sel       = 2'd0;
        out_ready = 1'b1;

        vecs[0] = '{2'd2, 4'b0100, 32'h00A5_0000, 4'b0100, 1'b1, 8'hA5};
        vecs[1] = '{2'd0, 4'b0001, 32'h4433_2211, 4'b0001, 1'b1, 8'h11};
        vecs[2] = '{2'd3, 4'b1000, 32'h4433_2211, 4'b1000, 1'b1, 8'h44};
        vecs[3] = '{2'd1, 4'b1101, 32'h4433_2211, 4'b0000, 1'b0, 8'h00};
        vecs[4] = '{2'd1, 4'b0010, 32'hDEAD_BEEF, 4'b0010, 1'b1, 8'hBE};
        vecs[5] = '{2'd0, 4'b1111, 32'hCAFE_0123, 4'b0001, 1'b1, 8'h23};
        vecs[6] = '{2'd3, 4'b0111, 32'hCAFE_0123, 4'b0000, 1'b0, 8'h00};
        vecs[7] = '{2'd3, 4'b1111, 32'h5A00_0000, 4'b1000, 1'b1, 8'h5A};

        do_reset();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_in_ready_idle", 32'(in_ready), 32'd0);

        // Explicit-select table
        for (int v = 0; v < 8; v++) begin
            mode     = 1'b0;
            sel      = vecs[v].sel;
            in_valid = vecs[v].valid;
            data_in  = vecs[v].data;
            #1;
            chk($sformatf("sel_tbl%0d_in_ready", v), 32'(in_ready), 32'(vecs[v].exp_ready));
            tick();
            chk($sformatf("sel_tbl%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].exp_ov));
            if (vecs[v].exp_ov) begin
                chk($sformatf("sel_tbl%0d_out_data", v), 32'(out_data), 32'(vecs[v].exp_data));
            end
        end

        // Round-robin fairness from reset
        do_reset();
        mode     = 1'b1;
        in_valid = 4'b1111;
        data_in  = 32'h1312_1110;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rr_fair%0d_in_ready", k), 32'(in_ready), 32'(1) << (k % 4));
            tick();
            chk($sformatf("rr_fair%0d_out_data", k), 32'(out_data), 32'h10 + 32'(k % 4));
            chk($sformatf("rr_fair%0d_out_valid", k), 32'(out_valid), 32'd1);
        end

        // Skip non-valid channels and wrap
        #1;
        chk("rr_skip_pre_in_ready", 32'(in_ready), 32'b0010);
        tick();
        chk("rr_skip_pre_data", 32'(out_data), 32'h11);
        in_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("rr_skip%0d_in_ready", k), 32'(in_ready), (k % 2 == 0) ? 32'b1000 : 32'b0010);
            tick();
            chk($sformatf("rr_skip%0d_out_data", k), 32'(out_data), (k % 2 == 0) ? 32'h13 : 32'h11);
        end

        // Stall for three cycles then release
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
            tick();
            chk($sformatf("stall%0d_out_data", k), 32'(out_data), 32'h13);
            chk($sformatf("stall%0d_out_valid", k), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("stall_release_in_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("stall_release_out_data", 32'(out_data), 32'h10);
        chk("stall_release_out_valid", 32'(out_valid), 32'd1);

        // Reset mid-stream
        rst = 1'b1;
        tick();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_first_grant", 32'(in_ready), 32'b0001);
        tick();
        chk("midrst_first_data", 32'(out_data), 32'h10);

`ifdef MUX_GRANT_CNT_EN
        do_reset();
        mode     = 1'b0;
        sel      = 2'd1;
        in_valid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            tick();
        end
        in_valid = 4'b0000;
        for (int c = 0; c < N; c++) begin
            chk($sformatf("grant_cnt_ch%0d", c), 32'(grant_cnt[c*CW +: CW]), (c == 1) ? 32'd3 : 32'd0);
        end
`endif

        // Randomized run against a behavioural model
        do_reset();
        m_ov   = 1'b0;
        m_data = 8'h00;
        m_last = N - 1;
        for (int t = 0; t < 400; t++) begin
            int         g;
            logic       load;
            logic [3:0] exp_ready;
            logic [7:0] cap;
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            data_in   = $urandom;
            #1;
            load = !m_ov || out_ready;
            g    = -1;
            if (mode == 1'b0) begin
                if (in_valid[sel]) g = int'(sel);
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (g < 0 && in_valid[c]) g = c;
                end
            end
            exp_ready = (load && g >= 0) ? 4'(1 << g) : 4'b0000;
            cap       = (g >= 0) ? data_in[g*W +: W] : 8'h00;
            chk($sformatf("rand%0d_in_ready", t), 32'(in_ready), 32'(exp_ready));
            tick();
            if (load) begin
                if (g >= 0) begin
                    m_ov   = 1'b1;
                    m_data = cap;
                    m_last = g;
                end else begin
                    m_ov = 1'b0;
                end
            end
            chk($sformatf("rand%0d_out_valid", t), 32'(out_valid), 32'(m_ov));
            if (m_ov) begin
                chk($sformatf("rand%0d_out_data", t), 32'(out_data), 32'(m_data));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_nto1_rr.md
Name: mux_nto1_rr

Overview:
- Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshake.
- Successor to the fixed 4:1 combinational mux. Adds a selectable channel count and width, a registered output stage, backpressure, and a round-robin arbitration mode alongside explicit select.
- Sits between several producer streams and one consumer, e.g. sensor/UART channels merging into a single datapath.

Parameters:
- N, 4, number of input channels; legal range N >= 2.
- W, 8, data width per channel in bits.
- SW, $clog2(N), select width (derived localparam, not overridable).
- CW, 16, width of the optional grant counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- data_in  in  N*W  flattened channel data; channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; one-hot or zero.
- mode  in  1  0 = explicit select, 1 = round-robin.
- sel  in  SW  channel index, used only when mode=0.
- out_data  out  W  registered selected data.
- out_valid  out  1  output holds valid data.
- out_ready  in  1  consumer accepts the output this cycle.
- grant_cnt  out  N*CW  per-channel grant counts; present only with MUX_GRANT_CNT_EN.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, last_grant=N-1 (so channel 0 wins first under round-robin), grant_cnt all 0.
- Load enable: load = ~out_valid | out_ready. The output register is a single entry with full-throughput pass-through.
- Grant in mode 0: grant channel sel when in_valid[sel]=1 and sel<N.
  - sel>=N (N not a power of two): no grant, all in_ready=0.
- Grant in mode 1: first channel with in_valid=1, searching cyclically from last_grant+1 and wrapping N-1 -> 0.
  - No valid channel: no grant.
- in_ready[g]=1 only when load=1 and channel g is granted; all other bits are 0. This is combinational from in_valid, sel, mode, out_valid and out_ready.
- Transfer on channel g occurs when in_valid[g] & in_ready[g]. On the next edge:
  - out_data <= channel g data;
  - out_valid <= 1;
  - last_grant <= g (last_grant updates only on a transfer, in either mode).
- Load with no grant: out_valid <= 0 on the next edge.
- Stall (out_valid=1, out_ready=0): out_data and out_valid hold; all in_ready=0.
- Latency: 1 cycle from input acceptance to out_valid. Sustains 1 transfer per cycle when out_ready is held at 1.
- Fairness: under round-robin, with all N channels continuously valid, grants cycle 0,1,...,N-1,0.
- mode and sel are sampled every cycle. Changing them mid-stream affects only the next grant; the held output is never corrupted.
- Reset asserted mid-stream: pending output data is dropped, out_valid=0 on the edge following rst=1, and arbitration restarts at channel 0.
- in_ready does not depend on rst; upstream must tolerate handshakes being ignored while in reset.

Optional Feature:
- Macro: MUX_GRANT_CNT_EN.
- Defined: per-channel CW-bit counters increment on each transfer from that channel. Counters saturate at 2^CW-1, reset to 0, and are exposed on grant_cnt.
- Undefined: the grant_cnt port and all counter logic are absent. The rest of the behaviour is identical.

Decomposition:
- Shared package mux_pkg holds:
  - MODE_SEL=1'b0 and MODE_RR=1'b1 constants;
  - default N/W/CW constants;
  - a function returning the next round-robin index.
- One sub-module, rr_arbiter: inputs req[N] and last_grant; outputs grant_valid and grant index.
- Top level holds the select-mode path, handshake logic, output register and optional counters.

Test Plan:
- Reset then mode=0, sel=2, data_in ch2=8'hA5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_valid=1.
- mode=1, in_valid=4'b1111, out_ready=1, data ch0..3 = 8'h10,11,12,13 -> out_data sequence 10,11,12,13,10; each in_ready one-hot in that order.
- mode=1, in_valid=4'b1010 after grant to ch1 -> next grant ch3, then ch1 (skips non-valid channels, wraps correctly).
- Output stalled: out_valid=1, out_ready=0 for 3 cycles with in_valid=4'b1111 -> in_ready=0 and out_data stable; release out_ready -> next transfer completes in 1 cycle.
- rst pulsed while out_valid=1 -> out_valid=0 next cycle; first round-robin grant afterwards is ch0.
- With MUX_GRANT_CNT_EN, CW=2: 5 transfers from ch1 -> grant_cnt[ch1]=3 (saturated), others 0.
